// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned N_DEFAULT    = 4;

    // aluoperation codes as produced by the ALU control stage
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter: loads an operand and a count, then moves one bit per cycle.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            kill,
    input  shift_kind_t     kind_in,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      amount,
    output logic [XLEN-1:0] data_next,
    output logic            done
);

    logic [XLEN-1:0] shreg;
    logic [4:0]      count;
    shift_kind_t     kind;

    // One-bit step of the held value; this is what lands in shreg next cycle
    always_comb begin
        data_next = shreg;
        case (kind)
            SH_LL:   data_next = {shreg[XLEN-2:0], 1'b0};
            SH_RL:   data_next = {1'b0, shreg[XLEN-1:1]};
            default: data_next = {shreg[XLEN-1], shreg[XLEN-1:1]};
        endcase
    end

    // The last step is taken on the edge where count goes 1 -> 0
    assign done = (count == 5'd1);

    // Shift register and remaining-step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
            kind  <= SH_LL;
        end else if (kill) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= data_in;
            count <= amount;
            kind  <= kind_in;
        end else if (count != 5'd0) begin
            shreg <= data_next;
            count <= count - 5'd1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake and a multi-cycle shift path.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned N    = N_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    aluoperation,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] single_res;
    logic            is_shift;
    shift_kind_t     kind;
    logic [4:0]      shamt;
    logic            lt;
    logic            accept;
    logic            shift_load;
    logic [XLEN-1:0] shift_next;
    logic            shift_done;

    assign shamt      = op_b[4:0];
    assign lt         = ($signed(op_a) < $signed(op_b));
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept     = in_valid && in_ready;
    assign shift_load = accept && is_shift && (shamt != 5'd0);

    // Single-cycle result; a shift by zero simply passes op_a through
    always_comb begin
        single_res = '0;
        is_shift   = 1'b0;
        kind       = SH_LL;
        case (aluoperation)
            N'(OP_AND): single_res = op_a & op_b;
            N'(OP_OR):  single_res = op_a | op_b;
            N'(OP_ADD): single_res = op_a + op_b;
            N'(OP_SUB): single_res = op_a - op_b;
            N'(OP_SLT): single_res = {{(XLEN-1){1'b0}}, lt};
            N'(OP_SLL): begin single_res = op_a; is_shift = 1'b1; kind = SH_LL; end
            N'(OP_SRL): begin single_res = op_a; is_shift = 1'b1; kind = SH_RL; end
            N'(OP_SRA): begin single_res = op_a; is_shift = 1'b1; kind = SH_RA; end
            default:    single_res = '0;
        endcase
    end

    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (shift_load),
        .kill      (flush),
        .kind_in   (kind),
        .data_in   (op_a),
        .amount    (shamt),
        .data_next (shift_next),
        .done      (shift_done)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: flush wins, otherwise enter SHIFT on a multi-cycle shift
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (shift_load) state_next = SHIFT;
                SHIFT:   if (shift_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output register: flush, then new request, then shift completion, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (shift_load) begin
                out_valid <= 1'b0;
            end else begin
                result    <= single_res;
                zero      <= (single_res == '0);
                out_valid <= 1'b1;
            end
        end else if ((state == SHIFT) && shift_done) begin
            result    <= shift_next;
            zero      <= (shift_next == '0);
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes expected results, monitor pops on handshake.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluoperation;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        z;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   last_wait;

    alu_exec #(.XLEN(32), .N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aluoperation (aluoperation),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input bit expect_out);
        int n;
        in_valid     = 1'b1;
        aluoperation = op;
        op_a         = a;
        op_b         = b;
        #1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_wait = n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 want 1 (op %b)", op);
        end else if (expect_out) begin
            exp_t e;
            e.res = er;
            e.z   = ez;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compares against the scoreboard whenever a result is presented
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h want no output", result);
                end else if (!out_ready) begin
                    chk("hold_result", result, sb[0].res);
                    chk("hold_zero", {31'b0, zero}, {31'b0, sb[0].z});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("zero", {31'b0, zero}, {31'b0, e.z});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[13];
        vt[0]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        vt[1]  = '{4'b1111, 32'h1234,      32'h5678,      32'h0,         1'b1};
        vt[2]  = '{4'b0001, 32'hA0,        32'h05,        32'hA5,        1'b0};
        vt[3]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vt[4]  = '{4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0};
        vt[5]  = '{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1};
        vt[6]  = '{4'b0111, 32'h5,         32'h5,         32'h0,         1'b1};
        vt[7]  = '{4'b0100, 32'h8000_0000, 32'd31,        32'h1,         1'b0};
        vt[8]  = '{4'b0011, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0};
        vt[9]  = '{4'b0100, 32'hF000_0000, 32'd4,         32'h0F00_0000, 1'b0};
        vt[10] = '{4'b0011, 32'h1,         32'h21,        32'h2,         1'b0};
        vt[11] = '{4'b0101, 32'h7FFF_FFFF, 32'd1,         32'h3FFF_FFFF, 1'b0};
        vt[12] = '{4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        aluoperation = 4'b0;
        op_a         = '0;
        op_b         = '0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        last_wait    = 0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // ADD 5+7: valid right after the accepting edge
        send(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        #1;
        chk("add_latency", {31'b0, out_valid}, 32'd1);
        @(negedge clk);

        // SUB then AND back-to-back
        send(4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
        send(4'b0000, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b1);
        chk("b2b_wait", last_wait, 32'd0);
        #1;
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);

        // SRA 0x80000000 by 4: busy for four cycles
        send(4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("sra_busy_ready", {31'b0, in_ready}, 32'd0);
            chk("sra_busy_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("sra_done_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);

        // Backpressure: result held for three cycles
        out_ready = 1'b0;
        send(4'b0010, 32'h10, 32'h20, 32'h30, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("release_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);

        // SLL 1 by 10, flushed on the third edge after acceptance
        send(4'b0011, 32'd1, 32'd10, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_idle", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("flush_quiet", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        send(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);

        // Directed table: SLT, illegal code, wrap, shifts incl. shamt 0
        for (int i = 0; i < 13; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].z, 1'b1);
        end
        @(negedge clk);

        // Reset in the middle of an SRL
        send(4'b0100, 32'hF000_0000, 32'd8, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("midrst_quiet", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        send(4'b0001, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter XLEN, default 32, operand/result width in bits.
REQ-003 Parameter N, default 4, aluoperation width; same encoding as the ALU control stage output.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 aluoperation  input  N  operation select from alu_control.
REQ-009 op_a  input  XLEN  first operand (rs1).
REQ-010 op_b  input  XLEN  second operand (rs2/imm); op_b[4:0] is the shift amount.
REQ-011 flush  input  1  synchronous kill of in-flight and pending results.
REQ-012 out_valid  output  1  result and zero are valid.
REQ-013 out_ready  input  1  downstream consumes result this cycle.
REQ-014 result  output  XLEN  registered operation result.
REQ-015 zero  output  1  registered (result == 0), for branch resolution.

Function
REQ-016 Encodings SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLL, 0100 SRL, 0101 SRA; any other code yields result 0, zero 1, single-cycle latency.
REQ-017 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush.
REQ-018 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready) && !flush.
REQ-019 States SHALL be IDLE and SHIFT; IDLE->SHIFT on acceptance of SLL/SRL/SRA with shamt != 0; SHIFT->IDLE when the shift count reaches 0 or on flush.
REQ-020 AND/OR/ADD/SUB/SLT and shifts with shamt 0 SHALL have latency 1: result/zero/out_valid update on the accepting edge.
REQ-021 Shifts with shamt k (1..31) SHALL shift one bit per cycle; out_valid rises on the k-th edge after the accepting edge (k+1 edges total).
REQ-022 ADD/SUB SHALL wrap modulo 2^XLEN with no overflow flag; SLT result is 1 or 0 zero-extended.
REQ-023 SRA SHALL replicate op_a[XLEN-1]; SRL and SLL fill with 0.
REQ-024 While out_valid && !out_ready, result and zero SHALL hold stable and no request is accepted.
REQ-025 out_valid SHALL clear on an edge with out_ready high unless a new single-cycle result loads on that same edge (back-to-back throughput 1/cycle).
REQ-026 Flush SHALL have priority over all other events: on that edge out_valid clears, state returns to IDLE, shift is discarded, no request is accepted.
REQ-027 A shift completing on an edge where the previous result is still unconsumed SHALL NOT occur, guaranteed by REQ-018.

Reset
REQ-028 On rst_n low: state IDLE, out_valid 0, result 0, zero 1, shift count 0, shift register 0; in_ready is 1 from the first edge after rst_n rises.
REQ-029 Reset asserted mid-shift SHALL abandon the operation with no output produced.

Structure
REQ-030 Shared package alu_pkg SHALL hold aluoperation code constants, the state enum, and default XLEN.
REQ-031 One sub-module alu_shifter SHALL implement the iterative one-bit-per-cycle shift (load, step, done).

Verification
REQ-032 ADD 5+7, out_ready=1 -> result 12, zero 0, out_valid one cycle after acceptance.
REQ-033 SUB 9-9 then AND 0xF0&0x0F back-to-back -> results 0 and 0, zero 1 both, one result per cycle.
REQ-034 SRA 0x80000000 by 4 -> in_ready 0 for 4 cycles, result 0xF8000000 after 4th post-accept edge.
REQ-035 ADD result with out_ready=0 for 3 cycles -> result held, in_ready 0, then released when out_ready=1.
REQ-036 SLL 1 by 10, flush asserted 3 cycles in -> out_valid never rises, state IDLE, next ADD 1+1 gives 2.
REQ-037 SLT 0xFFFFFFFF vs 1 -> result 1; code 1111 -> result 0, zero 1; rst_n low mid-SRL -> out_valid 0, result 0.
